// File: rtl/linear_interpolation.sv
// -----------------------------------------------------------------------------
// linear_interpolation
//
// Pipelined per-component blend between two data words:
//    result = (d0*(2^R - r) + d1*r + rnd) >>> R,  R = RATE_WIDTH
// Each DATA_WIDTH slice of the data words is processed independently. A
// sideband user field and the valid flag travel alongside the data with the
// same latency (3 cke-qualified clocks, or 2 when COMPACT=1). cke=0 freezes
// every pipeline register. Reset clears the whole pipeline, even with cke=0.
//
// Ports:
//    clk      clock
//    reset    synchronous, active-high reset
//    cke      clock enable for all pipeline registers
//    s_user   sideband in (width 1 and ignored when USER_WIDTH=0)
//    s_rate   unsigned interpolation rate r, weight = r / 2^RATE_WIDTH
//    s_data0  endpoint 0 components
//    s_data1  endpoint 1 components
//    s_valid  input valid
//    m_user   delayed s_user (0 when USER_WIDTH=0)
//    m_data   interpolated components
//    m_valid  output valid
// -----------------------------------------------------------------------------
module linear_interpolation #(
   parameter  int USER_WIDTH    = 0,
   parameter  int RATE_WIDTH    = 4,
   parameter  int COMPONENT_NUM = 1,
   parameter  int DATA_WIDTH    = 8,
   parameter  int DATA_SIGNED   = 1,
   parameter  int ROUNDING      = 0,
   parameter  int COMPACT       = 0,
   parameter  int BLENDING      = 0,
   localparam int USER_BITS     = (USER_WIDTH > 0) ? USER_WIDTH : 1,
   localparam int WORD_WIDTH    = COMPONENT_NUM * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cke,
   input  logic [USER_BITS-1:0]  s_user,
   input  logic [RATE_WIDTH-1:0] s_rate,
   input  logic [WORD_WIDTH-1:0] s_data0,
   input  logic [WORD_WIDTH-1:0] s_data1,
   input  logic                  s_valid,
   output logic [USER_BITS-1:0]  m_user,
   output logic [WORD_WIDTH-1:0] m_data,
   output logic                  m_valid
);

   // Arithmetic width: one extra bit for unsigned-to-signed extension, one
   // for the (2^R - r) weight sign, plus headroom for the sum of two terms.
   localparam int PW = DATA_WIDTH + RATE_WIDTH + 4;

   localparam logic signed [PW-1:0] ONE = PW'(1) <<< RATE_WIDTH;
   localparam logic signed [PW-1:0] RND = (ROUNDING != 0) ? (ONE >>> 1) : '0;
   localparam logic [USER_BITS-1:0] USER_MASK = (USER_WIDTH > 0) ? '1 : '0;

   logic [USER_BITS-1:0] user_in;

   // stage A: operands feeding the multipliers
   logic [USER_BITS-1:0]  a_user;
   logic [RATE_WIDTH-1:0] a_rate;
   logic [WORD_WIDTH-1:0] a_data0;
   logic [WORD_WIDTH-1:0] a_data1;
   logic                  a_valid;

   // stage B: registered product terms (per component, inside g_comp)
   logic [USER_BITS-1:0]  b_user_reg;
   logic                  b_valid_reg;

   // stage C: output registers
   logic [WORD_WIDTH-1:0] c_data_next;
   logic [WORD_WIDTH-1:0] c_data_reg;
   logic [USER_BITS-1:0]  c_user_reg;
   logic                  c_valid_reg;

   // With no user field the pipeline carries constant zero and folds away.
   assign user_in = s_user & USER_MASK;

   generate
      if (COMPACT == 0) begin : g_in_reg
         logic [USER_BITS-1:0]  user_reg;
         logic [RATE_WIDTH-1:0] rate_reg;
         logic [WORD_WIDTH-1:0] data0_reg;
         logic [WORD_WIDTH-1:0] data1_reg;
         logic                  valid_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               user_reg  <= '0;
               rate_reg  <= '0;
               data0_reg <= '0;
               data1_reg <= '0;
               valid_reg <= 1'b0;
            end else if (cke) begin
               user_reg  <= user_in;
               rate_reg  <= s_rate;
               data0_reg <= s_data0;
               data1_reg <= s_data1;
               valid_reg <= s_valid;
            end
         end

         assign a_user  = user_reg;
         assign a_rate  = rate_reg;
         assign a_data0 = data0_reg;
         assign a_data1 = data1_reg;
         assign a_valid = valid_reg;
      end else begin : g_in_pass
         assign a_user  = user_in;
         assign a_rate  = s_rate;
         assign a_data0 = s_data0;
         assign a_data1 = s_data1;
         assign a_valid = s_valid;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < COMPONENT_NUM; gi++) begin : g_comp
         logic [DATA_WIDTH-1:0] d0_raw;
         logic [DATA_WIDTH-1:0] d1_raw;
         logic                  d0_fill;
         logic                  d1_fill;
         logic signed [PW-1:0]  d0_ext;
         logic signed [PW-1:0]  d1_ext;
         logic signed [PW-1:0]  rate_ext;
         logic signed [PW-1:0]  term_a_next;
         logic signed [PW-1:0]  term_b_next;
         logic signed [PW-1:0]  term_a_reg;
         logic signed [PW-1:0]  term_b_reg;
         logic signed [PW-1:0]  sum;

         assign d0_raw   = a_data0[gi*DATA_WIDTH +: DATA_WIDTH];
         assign d1_raw   = a_data1[gi*DATA_WIDTH +: DATA_WIDTH];
         assign d0_fill  = (DATA_SIGNED != 0) && d0_raw[DATA_WIDTH-1];
         assign d1_fill  = (DATA_SIGNED != 0) && d1_raw[DATA_WIDTH-1];
         assign d0_ext   = {{(PW-DATA_WIDTH){d0_fill}}, d0_raw};
         assign d1_ext   = {{(PW-DATA_WIDTH){d1_fill}}, d1_raw};
         assign rate_ext = {{(PW-RATE_WIDTH){1'b0}}, a_rate};

         // Both forms give the same numerator once the two terms are summed:
         //    d0*(2^R - r) + d1*r  ==  d0*2^R + (d1 - d0)*r
         if (BLENDING != 0) begin : g_two_mul
            assign term_a_next = d0_ext * (ONE - rate_ext);
            assign term_b_next = d1_ext * rate_ext;
         end else begin : g_one_mul
            assign term_a_next = d0_ext <<< RATE_WIDTH;
            assign term_b_next = (d1_ext - d0_ext) * rate_ext;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               term_a_reg <= '0;
               term_b_reg <= '0;
            end else if (cke) begin
               term_a_reg <= term_a_next;
               term_b_reg <= term_b_next;
            end
         end

         // Arithmetic shift gives floor division; the result is bounded by
         // the two endpoints, so plain truncation never wraps.
         assign sum = term_a_reg + term_b_reg + RND;
         assign c_data_next[gi*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sum >>> RATE_WIDTH);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         b_user_reg  <= '0;
         b_valid_reg <= 1'b0;
         c_data_reg  <= '0;
         c_user_reg  <= '0;
         c_valid_reg <= 1'b0;
      end else if (cke) begin
         b_user_reg  <= a_user;
         b_valid_reg <= a_valid;
         c_data_reg  <= c_data_next;
         c_user_reg  <= b_user_reg;
         c_valid_reg <= b_valid_reg;
      end
   end

   assign m_data  = c_data_reg;
   assign m_user  = c_user_reg;
   assign m_valid = c_valid_reg;

endmodule

// File: tb/tb_linear_interpolation.sv
// -----------------------------------------------------------------------------
// tb_linear_interpolation
//
// Four instances share one stimulus stream, covering every BLENDING/COMPACT
// pairing, signed and unsigned data, both rounding modes and USER_WIDTH=0.
// A reference model computes each blend with plain integer arithmetic and
// delays it through a per-instance delay line of the instance's latency.
// -----------------------------------------------------------------------------
module tb_linear_interpolation;

   logic        clk;
   logic        reset;
   logic        cke;
   logic [7:0]  s_user;
   logic [7:0]  s_rate;
   logic [23:0] s_data0;
   logic [23:0] s_data1;
   logic        s_valid;

   logic [23:0] m_data_w  [4];
   logic [7:0]  m_user_w  [4];
   logic        m_valid_w [4];
   logic [0:0]  m_user3;

   int checks;
   int errors;

   // instance configs:
   //  0: unsigned, round, BLENDING=0, COMPACT=0
   //  1: unsigned, round, BLENDING=1, COMPACT=1
   //  2: signed,   round, BLENDING=1, COMPACT=0
   //  3: signed,   floor, BLENDING=0, COMPACT=1, no user field
   linear_interpolation #(.USER_WIDTH(8), .RATE_WIDTH(8), .COMPONENT_NUM(3), .DATA_WIDTH(8),
      .DATA_SIGNED(0), .ROUNDING(1), .COMPACT(0), .BLENDING(0)) dut0 (
      .clk(clk), .reset(reset), .cke(cke), .s_user(s_user), .s_rate(s_rate),
      .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
      .m_user(m_user_w[0]), .m_data(m_data_w[0]), .m_valid(m_valid_w[0]));

   linear_interpolation #(.USER_WIDTH(8), .RATE_WIDTH(8), .COMPONENT_NUM(3), .DATA_WIDTH(8),
      .DATA_SIGNED(0), .ROUNDING(1), .COMPACT(1), .BLENDING(1)) dut1 (
      .clk(clk), .reset(reset), .cke(cke), .s_user(s_user), .s_rate(s_rate),
      .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
      .m_user(m_user_w[1]), .m_data(m_data_w[1]), .m_valid(m_valid_w[1]));

   linear_interpolation #(.USER_WIDTH(8), .RATE_WIDTH(8), .COMPONENT_NUM(3), .DATA_WIDTH(8),
      .DATA_SIGNED(1), .ROUNDING(1), .COMPACT(0), .BLENDING(1)) dut2 (
      .clk(clk), .reset(reset), .cke(cke), .s_user(s_user), .s_rate(s_rate),
      .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
      .m_user(m_user_w[2]), .m_data(m_data_w[2]), .m_valid(m_valid_w[2]));

   linear_interpolation #(.USER_WIDTH(0), .RATE_WIDTH(8), .COMPONENT_NUM(3), .DATA_WIDTH(8),
      .DATA_SIGNED(1), .ROUNDING(0), .COMPACT(1), .BLENDING(0)) dut3 (
      .clk(clk), .reset(reset), .cke(cke), .s_user(s_user[0:0]), .s_rate(s_rate),
      .s_data0(s_data0), .s_data1(s_data1), .s_valid(s_valid),
      .m_user(m_user3), .m_data(m_data_w[3]), .m_valid(m_valid_w[3]));

   assign m_user_w[3] = {7'b0, m_user3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [23:0] mdl_data  [4][3];
   logic [7:0]  mdl_user  [4][3];
   logic        mdl_valid [4][3];

   function automatic int cfg_lat(int k);
      return (k == 1 || k == 3) ? 2 : 3;
   endfunction

   function automatic bit cfg_signed(int k);
      return (k >= 2);
   endfunction

   function automatic bit cfg_round(int k);
      return (k != 3);
   endfunction

   function automatic bit cfg_user(int k);
      return (k != 3);
   endfunction

   function automatic logic [23:0] blend(logic [23:0] d0, logic [23:0] d1, logic [7:0] r,
                                         bit sgn, bit rnd);
      logic [23:0] res;
      logic [7:0]  b0;
      logic [7:0]  b1;
      longint      a;
      longint      b;
      longint      rr;
      longint      num;
      res = '0;
      rr  = longint'(r);
      for (int c = 0; c < 3; c++) begin
         b0 = d0[c*8 +: 8];
         b1 = d1[c*8 +: 8];
         a  = sgn ? longint'($signed(b0)) : longint'(b0);
         b  = sgn ? longint'($signed(b1)) : longint'(b1);
         num = a * (256 - rr) + b * rr + (rnd ? 128 : 0);
         res[c*8 +: 8] = 8'(num >>> 8);
      end
      return res;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 4; k++) begin
         if (reset) begin
            for (int j = 0; j < 3; j++) begin
               mdl_data[k][j]  = '0;
               mdl_user[k][j]  = '0;
               mdl_valid[k][j] = 1'b0;
            end
         end else if (cke) begin
            for (int j = cfg_lat(k) - 1; j > 0; j--) begin
               mdl_data[k][j]  = mdl_data[k][j-1];
               mdl_user[k][j]  = mdl_user[k][j-1];
               mdl_valid[k][j] = mdl_valid[k][j-1];
            end
            mdl_data[k][0]  = blend(s_data0, s_data1, s_rate, cfg_signed(k), cfg_round(k));
            mdl_user[k][0]  = cfg_user(k) ? s_user : 8'h00;
            mdl_valid[k][0] = s_valid;
         end
      end
   endtask

   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         chk("valid", k, 32'(m_valid_w[k]), 32'(mdl_valid[k][cfg_lat(k)-1]));
         chk("data",  k, 32'(m_data_w[k]),  32'(mdl_data[k][cfg_lat(k)-1]));
         chk("user",  k, 32'(m_user_w[k]),  32'(mdl_user[k][cfg_lat(k)-1]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // One valid sample followed by held data; known answers checked at the
   // exact latency of each instance.
   task automatic directed(logic [23:0] d0, logic [23:0] d1, logic [7:0] r,
                           logic [23:0] exp_u, logic [23:0] exp_sr, logic [23:0] exp_sf);
      s_data0 = d0;
      s_data1 = d1;
      s_rate  = r;
      s_user  = r ^ 8'h5A;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      step();
      chk("dir_valid_lat2", 1, 32'(m_valid_w[1]), 32'd1);
      chk("dir_data_lat2",  1, 32'(m_data_w[1]),  32'(exp_u));
      chk("dir_valid_lat2", 3, 32'(m_valid_w[3]), 32'd1);
      chk("dir_data_lat2",  3, 32'(m_data_w[3]),  32'(exp_sf));
      step();
      chk("dir_valid_lat3", 0, 32'(m_valid_w[0]), 32'd1);
      chk("dir_data_lat3",  0, 32'(m_data_w[0]),  32'(exp_u));
      chk("dir_user_lat3",  0, 32'(m_user_w[0]),  32'(r ^ 8'h5A));
      chk("dir_valid_lat3", 2, 32'(m_valid_w[2]), 32'd1);
      chk("dir_data_lat3",  2, 32'(m_data_w[2]),  32'(exp_sr));
      step();
   endtask

   logic [23:0] snap_data  [4];
   logic [7:0]  snap_user  [4];
   logic        snap_valid [4];

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      cke     = 1'b1;
      s_user  = '0;
      s_rate  = '0;
      s_data0 = '0;
      s_data1 = '0;
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 3; j++) begin
            mdl_data[k][j]  = '0;
            mdl_user[k][j]  = '0;
            mdl_valid[k][j] = 1'b0;
         end

      // reset, including one reset cycle with cke low
      step();
      cke = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("reset_valid", k, 32'(m_valid_w[k]), 32'd0);
         chk("reset_data",  k, 32'(m_data_w[k]),  32'd0);
      end
      reset = 1'b0;
      cke   = 1'b1;
      step();

      //        d0           d1           r      unsigned     signed rnd   signed floor
      directed(24'h000000, 24'hFFFFFF, 8'h00, 24'h000000, 24'h000000, 24'h000000);
      directed(24'h000000, 24'hFFFFFF, 8'h80, 24'h808080, 24'h000000, 24'hFFFFFF);
      directed(24'h000000, 24'hFFFFFF, 8'hFF, 24'hFEFEFE, 24'hFFFFFF, 24'hFFFFFF);
      directed(24'h7FFF00, 24'h8000FF, 8'h40, 24'h7FBF40, 24'h3FFF00, 24'h3FFFFF);
      directed(24'h7F7F7F, 24'h808080, 8'h80, 24'h808080, 24'h000000, 24'hFFFFFF);

      // random stream with random cke, a 5-cycle stall and a mid-stream reset
      for (int i = 0; i < 400; i++) begin
         s_data0 = s_data0 + 24'h010203;
         s_data1 = 24'($urandom);
         s_rate  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         s_user  = 8'(i);
         s_valid = ($urandom_range(0, 9) < 7);
         cke     = ($urandom_range(0, 3) != 0);
         if (i >= 246 && i < 250) begin
            cke     = 1'b1;
            s_valid = 1'b1;
         end
         if (i == 150) begin
            for (int k = 0; k < 4; k++) begin
               snap_data[k]  = mdl_data[k][cfg_lat(k)-1];
               snap_user[k]  = mdl_user[k][cfg_lat(k)-1];
               snap_valid[k] = mdl_valid[k][cfg_lat(k)-1];
            end
         end
         if (i >= 150 && i < 155) begin
            cke = 1'b0;
            step();
            for (int k = 0; k < 4; k++) begin
               chk("stall_valid", k, 32'(m_valid_w[k]), 32'(snap_valid[k]));
               chk("stall_data",  k, 32'(m_data_w[k]),  32'(snap_data[k]));
               chk("stall_user",  k, 32'(m_user_w[k]),  32'(snap_user[k]));
            end
         end else if (i == 250) begin
            reset = 1'b1;
            step();
            for (int k = 0; k < 4; k++) begin
               chk("midrst_valid", k, 32'(m_valid_w[k]), 32'd0);
               chk("midrst_data",  k, 32'(m_data_w[k]),  32'd0);
            end
            reset = 1'b0;
         end else begin
            step();
         end
      end

      // drain
      cke     = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
